// File: rtl/jtvigil_bank_pkg.sv
// Shared types and constants for the three-way SDRAM bank 0 read arbiter.
package jtvigil_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SLOT_MAIN = 2'd0;
    localparam logic [1:0] SLOT_SND  = 2'd1;
    localparam logic [1:0] SLOT_PCM  = 2'd2;

    localparam logic [21:0] DEF_MAIN_OFFSET = 22'h00000;
    localparam logic [21:0] DEF_SND_OFFSET  = 22'h20000;
    localparam logic [21:0] DEF_PCM_OFFSET  = 22'h28000;

    // Round-robin successor in the order main -> snd -> pcm -> main.
    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return (s == SLOT_PCM) ? SLOT_MAIN : s + 2'd1;
    endfunction

endpackage

// File: rtl/jtvigil_bank_arb_if.sv
// SDRAM bank read handshake between the arbiter (master) and the controller (slave).
interface jtvigil_bank_arb_if;
    logic [21:0] ba_addr;
    logic        ba_rd;
    logic        ba_ack;
    logic        ba_dst;
    logic        ba_dok;
    logic        ba_rdy;
    logic [15:0] data_read;

    modport master (
        output ba_addr, ba_rd,
        input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read
    );

    modport slave (
        input  ba_addr, ba_rd,
        output ba_ack, ba_dst, ba_dok, ba_rdy, data_read
    );
endinterface

// File: rtl/jtvigil_bank_slot.sv
// One-word cache for a byte-wide ROM requester: tag, word, valid, hit and byte select.
module jtvigil_bank_slot #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          load,
    input  logic          keep,
    input  logic [AW-2:0] load_tag,
    input  logic [15:0]   load_word,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [7:0]    data,
    output logic          ok,
    output logic          miss
);

    logic [AW-2:0] tag;
    logic [15:0]   word;
    logic          valid;
    logic          hit;

    // Capture fetched words; valid only if the requester still wants that word and it was not flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag   <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else begin
            if (load) begin
                tag  <= load_tag;
                word <= load_word;
            end
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= keep && (addr[AW-1:1] == load_tag);
            end
        end
    end

    // Hit and byte select follow the address combinationally so ok drops with an address change.
    always_comb begin
        hit  = cs && valid && (tag == addr[AW-1:1]);
        ok   = hit;
        miss = cs && !hit;
        data = addr[0] ? word[15:8] : word[7:0];
    end

endmodule

// File: rtl/jtvigil_bank_arb.sv
// Shares SDRAM bank 0 between main CPU, sound CPU and PCM ROM with per-port one-word caches.
module jtvigil_bank_arb
    import jtvigil_bank_pkg::*;
#(
    parameter int          MAIN_AW     = 18,
    parameter int          SND_AW      = 16,
    parameter int          PCM_AW      = 16,
    parameter logic [21:0] MAIN_OFFSET = DEF_MAIN_OFFSET,
    parameter logic [21:0] SND_OFFSET  = DEF_SND_OFFSET,
    parameter logic [21:0] PCM_OFFSET  = DEF_PCM_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,
    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,
    input  logic               snd_cs,
    input  logic [SND_AW-1:0]  snd_addr,
    output logic [7:0]         snd_data,
    output logic               snd_ok,
    input  logic               pcm_cs,
    input  logic [PCM_AW-1:0]  pcm_addr,
    output logic [7:0]         pcm_data,
    output logic               pcm_ok,
    jtvigil_bank_arb_if.master ba
);

    state_t      state_q, state_d;
    logic        ba_rd_q, ba_rd_d;
    logic [21:0] ba_addr_q, ba_addr_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_q, rr_d;
    logic [21:0] tag_q, tag_d;
    logic        discard_q, discard_d;
    logic        load_en;
    logic [2:0]  miss;
    logic [1:0]  pick;
    logic        pick_found;
    logic [1:0]  idx;
    logic [21:0] pick_tag;
    logic [21:0] pick_offset;
    logic        unused_dst;

    assign unused_dst = ba.ba_dst;
    assign ba.ba_rd   = ba_rd_q;
    assign ba.ba_addr = ba_addr_q;

    jtvigil_bank_slot #(.AW(MAIN_AW)) u_main (
        .clk(clk), .rst(rst), .flush(downloading),
        .load(load_en && (grant_q == SLOT_MAIN)), .keep(!discard_q),
        .load_tag(tag_q[MAIN_AW-2:0]), .load_word(ba.data_read),
        .cs(main_cs), .addr(main_addr), .data(main_data), .ok(main_ok), .miss(miss[0])
    );

    jtvigil_bank_slot #(.AW(SND_AW)) u_snd (
        .clk(clk), .rst(rst), .flush(downloading),
        .load(load_en && (grant_q == SLOT_SND)), .keep(!discard_q),
        .load_tag(tag_q[SND_AW-2:0]), .load_word(ba.data_read),
        .cs(snd_cs), .addr(snd_addr), .data(snd_data), .ok(snd_ok), .miss(miss[1])
    );

    jtvigil_bank_slot #(.AW(PCM_AW)) u_pcm (
        .clk(clk), .rst(rst), .flush(downloading),
        .load(load_en && (grant_q == SLOT_PCM)), .keep(!discard_q),
        .load_tag(tag_q[PCM_AW-2:0]), .load_word(ba.data_read),
        .cs(pcm_cs), .addr(pcm_addr), .data(pcm_data), .ok(pcm_ok), .miss(miss[2])
    );

    // Round-robin pick: first missing slot starting at the pointer, plus its word tag and offset.
    always_comb begin
        pick       = rr_q;
        pick_found = 1'b0;
        idx        = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!pick_found && miss[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
            idx = next_slot(idx);
        end
        pick_tag    = 22'(main_addr[MAIN_AW-1:1]);
        pick_offset = MAIN_OFFSET;
        case (pick)
            SLOT_SND: begin
                pick_tag    = 22'(snd_addr[SND_AW-1:1]);
                pick_offset = SND_OFFSET;
            end
            SLOT_PCM: begin
                pick_tag    = 22'(pcm_addr[PCM_AW-1:1]);
                pick_offset = PCM_OFFSET;
            end
            default: ;
        endcase
    end

    // Next-state logic for the single-word read transaction.
    always_comb begin
        state_d   = state_q;
        ba_rd_d   = ba_rd_q;
        ba_addr_d = ba_addr_q;
        grant_d   = grant_q;
        tag_d     = tag_q;
        rr_d      = rr_q;
        discard_d = discard_q || downloading;
        load_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!downloading && pick_found) begin
                    grant_d   = pick;
                    tag_d     = pick_tag;
                    ba_addr_d = pick_offset + pick_tag;
                    ba_rd_d   = 1'b1;
                    discard_d = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ba.ba_ack) begin
                    ba_rd_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                load_en = ba.ba_dok;
                if (ba.ba_rdy) begin
                    state_d = ST_IDLE;
                    rr_d    = next_slot(grant_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; a download seen mid-transaction marks the fetched word as stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ba_rd_q   <= 1'b0;
            ba_addr_q <= '0;
            grant_q   <= SLOT_MAIN;
            rr_q      <= SLOT_MAIN;
            tag_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ba_rd_q   <= ba_rd_d;
            ba_addr_q <= ba_addr_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            tag_q     <= tag_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_jtvigil_bank_arb.sv
// Self-checking bench for jtvigil_bank_arb with a simple SDRAM bank model and request scoreboard.
module tb_jtvigil_bank_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic        main_cs = 1'b0;
    logic [17:0] main_addr = '0;
    logic [7:0]  main_data;
    logic        main_ok;
    logic        snd_cs = 1'b0;
    logic [15:0] snd_addr = '0;
    logic [7:0]  snd_data;
    logic        snd_ok;
    logic        pcm_cs = 1'b0;
    logic [15:0] pcm_addr = '0;
    logic [7:0]  pcm_data;
    logic        pcm_ok;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          req_count = 0;
    int          dok_gap = 0;
    logic [21:0] exp_addr_q[$];

    jtvigil_bank_arb_if ba();

    jtvigil_bank_arb dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
        .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
        .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
        .ba(ba)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sdram_word(input logic [21:0] a);
        return {a[7:0] ^ 8'hA4, a[7:0] ^ 8'h5B};
    endfunction

    function automatic logic get_ok(input int idx);
        return (idx == 0) ? main_ok : (idx == 1) ? snd_ok : pcm_ok;
    endfunction

    // SDRAM model: ack one cycle after ba_rd, then dok+rdy after dok_gap more cycles; checks request order.
    initial begin
        logic [21:0] req_addr;
        logic [21:0] exp;
        ba.ba_ack = 1'b0; ba.ba_dst = 1'b0; ba.ba_dok = 1'b0; ba.ba_rdy = 1'b0; ba.data_read = '0;
        forever begin
            @(negedge clk);
            if (ba.ba_rd) begin
                req_addr = ba.ba_addr;
                req_count++;
                tests_run++;
                if (downloading) begin
                    tests_failed++;
                    $display("[TB] FAIL req_during_download: ba_rd=1 ba_addr=%h, required no request", req_addr);
                end
                tests_run++;
                if (exp_addr_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL unexpected_req: ba_addr=%h, required no request", req_addr);
                end else begin
                    exp = exp_addr_q.pop_front();
                    if (req_addr !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL ba_addr: got %h required %h", req_addr, exp);
                    end
                end
                ba.ba_ack = 1'b1;
                @(negedge clk);
                ba.ba_ack = 1'b0;
                repeat (dok_gap) @(negedge clk);
                ba.data_read = sdram_word(req_addr);
                ba.ba_dst = 1'b1; ba.ba_dok = 1'b1; ba.ba_rdy = 1'b1;
                @(negedge clk);
                ba.ba_dst = 1'b0; ba.ba_dok = 1'b0; ba.ba_rdy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input int idx, output bit seen);
        int n;
        n = 0;
        while (!get_ok(idx) && n < 80) begin
            step();
            n++;
        end
        seen = get_ok(idx);
    endtask

    task automatic wait_req(input int rc, output bit seen);
        int n;
        n = 0;
        while (req_count == rc && n < 40) begin
            step();
            n++;
        end
        seen = (req_count != rc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
        main_addr = 18'h00003; snd_addr = 16'h0010; pcm_addr = 16'h0001;
        repeat (3) step();
        tests_run++;
        if (ba.ba_rd !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ba_rd: got %b required 0", ba.ba_rd); end
        tests_run++;
        if (ba.ba_addr !== 22'h0) begin tests_failed++; $display("[TB] FAIL reset_ba_addr: got %h required 0", ba.ba_addr); end
        tests_run++;
        if ({main_ok, snd_ok, pcm_ok} !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL reset_ok: got %b required 000", {main_ok, snd_ok, pcm_ok});
        end
        main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (req_count !== 0) begin tests_failed++; $display("[TB] FAIL reset_no_req: got %0d required 0", req_count); end
    endtask

    task automatic test_main_read();
        int lat;
        int rc;
        dok_gap = 0;
        exp_addr_q.push_back(22'h00001);
        main_addr = 18'h00003;
        main_cs = 1'b1;
        lat = 0;
        while (!main_ok && lat < 40) begin
            step();
            lat++;
        end
        tests_run++;
        if (main_ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL main_read_ok: got %b required 1", main_ok); end
        tests_run++;
        if (lat != 3) begin tests_failed++; $display("[TB] FAIL main_latency: got %0d required 3", lat); end
        tests_run++;
        if (main_data !== 8'hA5) begin tests_failed++; $display("[TB] FAIL main_data_hi: got %h required a5", main_data); end
        rc = req_count;
        main_addr = 18'h00002;
        #1;
        tests_run++;
        if (main_ok !== 1'b1 || main_data !== 8'h5A) begin
            tests_failed++; $display("[TB] FAIL main_data_lo: ok=%b data=%h required ok=1 data=5a", main_ok, main_data);
        end
        repeat (4) step();
        tests_run++;
        if (req_count != rc) begin tests_failed++; $display("[TB] FAIL main_hit_no_req: got %0d required %0d", req_count, rc); end
        main_cs = 1'b0;
    endtask

    task automatic test_offsets();
        bit seen;
        exp_addr_q.push_back(22'h20008);
        snd_addr = 16'h0010;
        snd_cs = 1'b1;
        wait_ok(1, seen);
        tests_run++;
        if (!seen || snd_data !== 8'h53) begin
            tests_failed++; $display("[TB] FAIL snd_offset: ok=%b data=%h required ok=1 data=53", seen, snd_data);
        end
        snd_cs = 1'b0;
        exp_addr_q.push_back(22'h28000);
        pcm_addr = 16'h0001;
        pcm_cs = 1'b1;
        wait_ok(2, seen);
        tests_run++;
        if (!seen || pcm_data !== 8'hA4) begin
            tests_failed++; $display("[TB] FAIL pcm_offset: ok=%b data=%h required ok=1 data=a4", seen, pcm_data);
        end
        pcm_cs = 1'b0;
    endtask

    task automatic test_contention();
        bit seen;
        exp_addr_q.push_back(22'h00080);
        exp_addr_q.push_back(22'h20100);
        exp_addr_q.push_back(22'h28180);
        exp_addr_q.push_back(22'h00200);
        main_addr = 18'h00100; snd_addr = 16'h0200; pcm_addr = 16'h0300;
        main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
        wait_ok(0, seen);
        tests_run++;
        if (!seen || main_data !== 8'hDB || snd_ok !== 1'b0 || pcm_ok !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cont_main_first: ok=%b data=%h snd_ok=%b pcm_ok=%b required 1/db/0/0", seen, main_data, snd_ok, pcm_ok);
        end
        main_addr = 18'h00401;
        wait_ok(1, seen);
        tests_run++;
        if (!seen || snd_data !== 8'h5B || pcm_ok !== 1'b0 || main_ok !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cont_snd_second: ok=%b data=%h pcm_ok=%b main_ok=%b required 1/5b/0/0", seen, snd_data, pcm_ok, main_ok);
        end
        wait_ok(2, seen);
        tests_run++;
        if (!seen || pcm_data !== 8'hDB || main_ok !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cont_pcm_third: ok=%b data=%h main_ok=%b required 1/db/0", seen, pcm_data, main_ok);
        end
        wait_ok(0, seen);
        tests_run++;
        if (!seen || main_data !== 8'hA4) begin
            tests_failed++; $display("[TB] FAIL cont_main_again: ok=%b data=%h required 1/a4", seen, main_data);
        end
        main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
    endtask

    task automatic test_addr_change();
        bit seen;
        bit bad_ok;
        int rc;
        int n;
        dok_gap = 4;
        exp_addr_q.push_back(22'h00008);
        exp_addr_q.push_back(22'h00010);
        rc = req_count;
        main_addr = 18'h00010;
        main_cs = 1'b1;
        wait_req(rc, seen);
        main_addr = 18'h00020;
        bad_ok = 1'b0;
        n = 0;
        while (req_count < rc + 2 && n < 40) begin
            if (main_ok) bad_ok = 1'b1;
            step();
            n++;
        end
        tests_run++;
        if (!seen || bad_ok || req_count != rc + 2) begin
            tests_failed++;
            $display("[TB] FAIL addr_change_refetch: first=%b stale_ok=%b reqs=%0d required 1/0/%0d", seen, bad_ok, req_count - rc, 2);
        end
        wait_ok(0, seen);
        tests_run++;
        if (!seen || main_data !== 8'h4B) begin
            tests_failed++; $display("[TB] FAIL addr_change_data: ok=%b data=%h required 1/4b", seen, main_data);
        end
        dok_gap = 0;
        main_cs = 1'b0;
    endtask

    task automatic test_download();
        bit seen;
        int rc;
        main_addr = 18'h00020; snd_addr = 16'h0200; pcm_addr = 16'h0300;
        main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
        #1;
        tests_run++;
        if ({main_ok, snd_ok, pcm_ok} !== 3'b111) begin
            tests_failed++; $display("[TB] FAIL dl_precondition: got %b required 111", {main_ok, snd_ok, pcm_ok});
        end
        rc = req_count;
        downloading = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if ({main_ok, snd_ok, pcm_ok} !== 3'b000 || req_count != rc) begin
                tests_failed++;
                $display("[TB] FAIL dl_hold: ok=%b reqs=%0d required ok=000 reqs=0", {main_ok, snd_ok, pcm_ok}, req_count - rc);
            end
        end
        exp_addr_q.push_back(22'h20100);
        exp_addr_q.push_back(22'h28180);
        exp_addr_q.push_back(22'h00010);
        downloading = 1'b0;
        wait_ok(0, seen);
        tests_run++;
        if (!seen || {main_ok, snd_ok, pcm_ok} !== 3'b111 || req_count != rc + 3) begin
            tests_failed++;
            $display("[TB] FAIL dl_refetch: ok=%b reqs=%0d required 111/3", {main_ok, snd_ok, pcm_ok}, req_count - rc);
        end
        tests_run++;
        if ({main_data, snd_data, pcm_data} !== {8'h4B, 8'h5B, 8'hDB}) begin
            tests_failed++; $display("[TB] FAIL dl_data: got %h %h %h required 4b 5b db", main_data, snd_data, pcm_data);
        end
        main_cs = 1'b0; snd_cs = 1'b0; pcm_cs = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        int rc;
        dok_gap = 3;
        exp_addr_q.push_back(22'h00020);
        rc = req_count;
        main_addr = 18'h00040;
        main_cs = 1'b1;
        wait_req(rc, seen);
        step();
        step();
        rst = 1'b1;
        main_cs = 1'b0;
        step();
        tests_run++;
        if (!seen || ba.ba_rd !== 1'b0 || {main_ok, snd_ok, pcm_ok} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL rst_wait_state: req=%b ba_rd=%b ok=%b required 1/0/000", seen, ba.ba_rd, {main_ok, snd_ok, pcm_ok});
        end
        rst = 1'b0;
        step();
        dok_gap = 0;
        main_cs = 1'b1; snd_cs = 1'b1; pcm_cs = 1'b1;
        #1;
        tests_run++;
        if ({main_ok, snd_ok, pcm_ok} !== 3'b000) begin
            tests_failed++; $display("[TB] FAIL rst_stray_dok: ok=%b required 000", {main_ok, snd_ok, pcm_ok});
        end
        snd_cs = 1'b0; pcm_cs = 1'b0;
        exp_addr_q.push_back(22'h00020);
        wait_ok(0, seen);
        tests_run++;
        if (!seen || main_data !== 8'h7B) begin
            tests_failed++; $display("[TB] FAIL rst_refetch: ok=%b data=%h required 1/7b", seen, main_data);
        end
        main_cs = 1'b0;
        repeat (4) step();
    endtask

    // Watchdog so a stuck handshake still ends the run with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_main_read();
        test_offsets();
        test_contention();
        test_addr_change();
        test_download();
        test_reset_mid_wait();
        tests_run++;
        if (exp_addr_q.size() != 0) begin
            tests_failed++; $display("[TB] FAIL missing_reqs: %0d outstanding, required 0", exp_addr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
